uart_dbg_loader: RTL and testbench
==================================

// Module: uart_dbg_loader
// PURPOSE
// Host-side program loader feeding the SoC debug memory port (dbg_mem_op/dbg_wren/dbg_adr/dbg_do/dbg_di).
// Consumes bytes from the UART receiver and decodes framed commands into word writes and reads.
// Controls cpu_n_reset: RAM is loaded while the core is halted, then the core is released.
// Replies to the host through the UART transmitter handshake.
// PARAMETERS
// WR_CYCLES    4      cycles each debug write is held on the bus (>=1)
// RD_CYCLES    2      cycles from read-address drive to dbg_di capture (>=1)
// TIMEOUT      50000  max idle cycles between bytes inside a frame
// BOOT_HALTED  1      cpu_n_reset value after reset is !BOOT_HALTED
// PORTS
// clk          in   1   system clock
// n_reset      in   1   asynchronous active-low reset
// rx_data      in   8   received byte, valid while rx_valid
// rx_valid     in   1   one-cycle strobe per received byte
// tx_data      out  8   byte to transmit
// tx_valid     out  1   transmit request, held until tx_ready
// tx_ready     in   1   transmitter accepts tx_data when tx_valid&&tx_ready
// dbg_mem_op   out  1   debug port owns memory bus
// dbg_wren     out  4   byte write enables (4'hF on write, 0 on read)
// dbg_adr      out  32  debug address
// dbg_do       out  32  debug write data
// dbg_di       in   32  debug read data
// cpu_n_reset  out  1   core reset, active low
// BEHAVIOUR
// Reset: dbg_mem_op=0, dbg_wren=0, dbg_adr=0, dbg_do=0, tx_valid=0, tx_data=0,
//   cpu_n_reset=!BOOT_HALTED; FSM=IDLE; counters cleared. Async reset mid-access aborts it instantly.
// Frames (multi-byte fields little-endian):
//   'W'(0x57) A0..A3 D0..D3 -> word write; 'R'(0x52) A0..A3 -> word read;
//   'H'(0x48) -> cpu_n_reset=0, ACK;  'G'(0x47) -> cpu_n_reset=1, ACK;  other -> NAK.
// ACK=0x06, NAK=0x15.
// States: IDLE, ADDR, DATA, WRITE, READ, TX_ACK, TX_NAK, TX_RD.
//   IDLE: rx byte decoded the cycle after the rx_valid strobe. W/R go to ADDR with a 2-bit byte counter at 0.
//   ADDR: collect 4 bytes. W goes to DATA, R goes to READ.
//   DATA: collect 4 bytes, then go to WRITE.
//   WRITE: dbg_mem_op=1, dbg_wren=4'hF, dbg_adr/dbg_do stable for exactly WR_CYCLES cycles.
//     Next cycle all dbg_* outputs return to 0, then TX_ACK.
//   READ: dbg_mem_op=1, dbg_wren=0, dbg_adr driven for RD_CYCLES cycles.
//     dbg_di captured on the last cycle, then TX_RD.
//   TX_RD: send 4 bytes LSB first, each held until tx_ready, then IDLE.
//   TX_ACK/TX_NAK: tx_valid=1 with the code until tx_ready, then IDLE.
// Memory commands while cpu_n_reset=1: frame fully consumed, no bus activity, NAK.
// Timeout: in ADDR or DATA, TIMEOUT cycles with no rx_valid -> discard frame, TX_NAK.
//   Counter clears on every rx_valid.
// rx_valid in WRITE, READ or any TX state: byte dropped, no state change.
// dbg_adr/dbg_do never change while dbg_mem_op=1; dbg_wren=0 whenever dbg_mem_op=0.
// tx_data stable while tx_valid=1 && !tx_ready.
// H while halted and G while running are legal no-ops; both ACK.
// TESTING
// 1. After reset, W 00 00 02 00 37 01 00 00 -> dbg_adr=0x00020000, dbg_do=0x00000137, wren=F for 4 cycles; tx 0x06.
// 2. W to 0x0000000C data 0x32, then R 0C 00 00 00 with dbg_di model=0x00000032 -> tx 32 00 00 00.
// 3. G -> cpu_n_reset=1, ACK; then W frame -> no dbg_mem_op pulse, tx 0x15; H -> cpu_n_reset=0.
// 4. 'X'(0x58) -> tx 0x15. Then W + 2 address bytes, stall TIMEOUT cycles -> tx 0x15, next frame decodes OK.
// 5. Hold tx_ready=0 for 20 cycles during ACK -> tx_valid/tx_data stable; bytes injected during WRITE ignored.
// 6. Assert n_reset=0 in cycle 2 of WRITE -> dbg_mem_op=0, dbg_wren=0 immediately, cpu_n_reset=0, FSM IDLE.

Source files
------------

// File: rtl/uart_dbg_loader.sv
// Host-side debug loader: decodes framed UART commands into debug-port word
// writes/reads, controls the core reset, and replies through the UART transmitter.
module uart_dbg_loader #(
    parameter int WR_CYCLES   = 4,
    parameter int RD_CYCLES   = 2,
    parameter int TIMEOUT     = 50000,
    parameter int BOOT_HALTED = 1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        dbg_mem_op,
    output logic [3:0]  dbg_wren,
    output logic [31:0] dbg_adr,
    output logic [31:0] dbg_do,
    input  logic [31:0] dbg_di,
    output logic        cpu_n_reset
);

    typedef enum logic [2:0] {
        IDLE, ADDR, DATA, WRITE, READ, TX_ACK, TX_NAK, TX_RD
    } state_t;

    localparam int CYC_MAX = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int TMO_W   = $clog2(TIMEOUT + 1);

    localparam logic [CYC_W-1:0] WR_LAST  = CYC_W'(WR_CYCLES - 1);
    localparam logic [CYC_W-1:0] RD_LAST  = CYC_W'(RD_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    state_t             state_q, state_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic               is_wr_q, is_wr_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [31:0]        rd_q, rd_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [1:0]         tx_idx_q, tx_idx_d;
    logic               dbg_mem_op_q, dbg_mem_op_d;
    logic [3:0]         dbg_wren_q, dbg_wren_d;
    logic [31:0]        dbg_adr_q, dbg_adr_d;
    logic [31:0]        dbg_do_q, dbg_do_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               cpu_n_reset_q, cpu_n_reset_d;

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        is_wr_d       = is_wr_q;
        addr_d        = addr_q;
        data_d        = data_q;
        rd_d          = rd_q;
        cyc_d         = cyc_q;
        tmo_d         = tmo_q;
        tx_idx_d      = tx_idx_q;
        dbg_mem_op_d  = dbg_mem_op_q;
        dbg_wren_d    = dbg_wren_q;
        dbg_adr_d     = dbg_adr_q;
        dbg_do_d      = dbg_do_q;
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        cpu_n_reset_d = cpu_n_reset_q;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_W, CMD_R: begin
                            is_wr_d    = (rx_data == CMD_W);
                            byte_cnt_d = 2'd0;
                            tmo_d      = '0;
                            state_d    = ADDR;
                        end
                        CMD_H, CMD_G: begin
                            cpu_n_reset_d = (rx_data == CMD_G);
                            tx_valid_d    = 1'b1;
                            tx_data_d     = ACK;
                            state_d       = TX_ACK;
                        end
                        default: begin
                            tx_valid_d = 1'b1;
                            tx_data_d  = NAK;
                            state_d    = TX_NAK;
                        end
                    endcase
                end
            end

            ADDR: begin
                if (rx_valid) begin
                    tmo_d      = '0;
                    addr_d     = {rx_data, addr_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (is_wr_q) begin
                            state_d = DATA;
                        end else if (!cpu_n_reset_q) begin
                            dbg_mem_op_d = 1'b1;
                            dbg_wren_d   = 4'h0;
                            dbg_adr_d    = addr_d;
                            cyc_d        = '0;
                            state_d      = READ;
                        end else begin
                            tx_valid_d = 1'b1;
                            tx_data_d  = NAK;
                            state_d    = TX_NAK;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = NAK;
                    state_d    = TX_NAK;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end

            // The memory bus is only touched while the core is held in reset.
            DATA: begin
                if (rx_valid) begin
                    tmo_d      = '0;
                    data_d     = {rx_data, data_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (!cpu_n_reset_q) begin
                            dbg_mem_op_d = 1'b1;
                            dbg_wren_d   = 4'hF;
                            dbg_adr_d    = addr_q;
                            dbg_do_d     = data_d;
                            cyc_d        = '0;
                            state_d      = WRITE;
                        end else begin
                            tx_valid_d = 1'b1;
                            tx_data_d  = NAK;
                            state_d    = TX_NAK;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = NAK;
                    state_d    = TX_NAK;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end

            WRITE: begin
                if (cyc_q == WR_LAST) begin
                    dbg_mem_op_d = 1'b0;
                    dbg_wren_d   = 4'h0;
                    dbg_adr_d    = '0;
                    dbg_do_d     = '0;
                    tx_valid_d   = 1'b1;
                    tx_data_d    = ACK;
                    state_d      = TX_ACK;
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end

            READ: begin
                if (cyc_q == RD_LAST) begin
                    rd_d         = dbg_di;
                    dbg_mem_op_d = 1'b0;
                    dbg_wren_d   = 4'h0;
                    dbg_adr_d    = '0;
                    dbg_do_d     = '0;
                    tx_idx_d     = 2'd0;
                    tx_valid_d   = 1'b1;
                    tx_data_d    = dbg_di[7:0];
                    state_d      = TX_RD;
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end

            TX_ACK, TX_NAK: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end

            // Read data goes out least significant byte first.
            TX_RD: begin
                if (tx_ready) begin
                    if (tx_idx_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        tx_idx_d  = tx_idx_q + 2'd1;
                        tx_data_d = rd_q[{tx_idx_d, 3'b000} +: 8];
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= IDLE;
            byte_cnt_q    <= 2'd0;
            is_wr_q       <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            rd_q          <= '0;
            cyc_q         <= '0;
            tmo_q         <= '0;
            tx_idx_q      <= 2'd0;
            dbg_mem_op_q  <= 1'b0;
            dbg_wren_q    <= 4'h0;
            dbg_adr_q     <= '0;
            dbg_do_q      <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            cpu_n_reset_q <= (BOOT_HALTED == 0);
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            is_wr_q       <= is_wr_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            rd_q          <= rd_d;
            cyc_q         <= cyc_d;
            tmo_q         <= tmo_d;
            tx_idx_q      <= tx_idx_d;
            dbg_mem_op_q  <= dbg_mem_op_d;
            dbg_wren_q    <= dbg_wren_d;
            dbg_adr_q     <= dbg_adr_d;
            dbg_do_q      <= dbg_do_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            cpu_n_reset_q <= cpu_n_reset_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign dbg_mem_op  = dbg_mem_op_q;
    assign dbg_wren    = dbg_wren_q;
    assign dbg_adr     = dbg_adr_q;
    assign dbg_do      = dbg_do_q;
    assign cpu_n_reset = cpu_n_reset_q;

endmodule

// File: tb/tb_uart_dbg_loader.sv
// Scoreboard bench for uart_dbg_loader: a frame-level reference model queues the
// expected bus accesses and reply bytes, and independent monitors compare them.
module tb_uart_dbg_loader;

    localparam int WR_CYCLES = 4;
    localparam int RD_CYCLES = 2;
    localparam int TIMEOUT   = 200;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic [31:0] dbg_di;
    logic        cpu_n_reset;

    uart_dbg_loader #(
        .WR_CYCLES(WR_CYCLES), .RD_CYCLES(RD_CYCLES),
        .TIMEOUT(TIMEOUT), .BOOT_HALTED(1)
    ) dut (
        .clk(clk), .n_reset(n_reset),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .dbg_mem_op(dbg_mem_op), .dbg_wren(dbg_wren), .dbg_adr(dbg_adr),
        .dbg_do(dbg_do), .dbg_di(dbg_di), .cpu_n_reset(cpu_n_reset)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_ev_t;

    bus_ev_t     bus_q[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  frame_bytes[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] slave_mem[logic [31:0]];

    int errors = 0;
    int checks = 0;
    int inv_viol = 0;
    int bus_stab_viol = 0;
    int tx_stab_viol = 0;
    logic halted = 1'b1;
    logic mon_en = 1'b1;
    logic hold_low = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hA5A5_5A5A);
    endfunction

    function automatic logic [31:0] slave_read(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : (a ^ 32'hA5A5_5A5A);
    endfunction

    // Memory slave on the debug port; read data settles well before the capture edge.
    always @(negedge clk) begin
        if (dbg_mem_op && dbg_wren == 4'hF) slave_mem[dbg_adr] = dbg_do;
        dbg_di = slave_read(dbg_adr);
    end

    always @(posedge clk) begin
        #1;
        tx_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Reply monitor: every accepted byte is popped from the expected queue.
    logic       p_hold = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic [7:0] exp_b;
    always @(negedge clk) begin
        if (!mon_en) begin
            p_hold = 1'b0;
        end else begin
            if (p_hold && (!tx_valid || tx_data != p_data)) tx_stab_viol++;
            p_hold = tx_valid && !tx_ready;
            p_data = tx_data;
            if (tx_valid && tx_ready) begin
                checkOutput("tx_byte_expected", 64'(exp_tx.size() != 0), 64'd1);
                if (exp_tx.size() != 0) begin
                    exp_b = exp_tx.pop_front();
                    checkOutput("tx_byte", 64'(tx_data), 64'(exp_b));
                end
            end
        end
    end

    // Bus monitor: measures each access window and checks it against the model.
    logic        in_acc = 1'b0;
    int          acc_len = 0;
    logic [31:0] c_adr, c_do;
    logic [3:0]  c_wren;
    bus_ev_t     ev;
    always @(negedge clk) begin
        if (!mon_en) begin
            in_acc = 1'b0;
        end else begin
            if (!dbg_mem_op && (dbg_wren != 4'h0 || dbg_adr != 32'h0 || dbg_do != 32'h0)) inv_viol++;
            if (dbg_mem_op) begin
                if (!in_acc) begin
                    in_acc  = 1'b1;
                    acc_len = 1;
                    c_adr   = dbg_adr;
                    c_do    = dbg_do;
                    c_wren  = dbg_wren;
                end else begin
                    acc_len++;
                    if (dbg_adr != c_adr || dbg_do != c_do || dbg_wren != c_wren) bus_stab_viol++;
                end
            end else if (in_acc) begin
                in_acc = 1'b0;
                checkOutput("bus_access_expected", 64'(bus_q.size() != 0), 64'd1);
                if (bus_q.size() != 0) begin
                    ev = bus_q.pop_front();
                    checkOutput("bus_wren", 64'(c_wren), ev.is_wr ? 64'hF : 64'h0);
                    checkOutput("bus_adr", 64'(c_adr), 64'(ev.adr));
                    if (ev.is_wr) checkOutput("bus_do", 64'(c_do), 64'(ev.dat));
                    checkOutput("bus_len", 64'(acc_len), ev.is_wr ? 64'(WR_CYCLES) : 64'(RD_CYCLES));
                end
            end
        end
    end

    // Reference model: the whole frame's outcome derived from the command rules.
    task automatic model_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        bus_ev_t e;
        frame_bytes.delete();
        frame_bytes.push_back(cmd);
        if (cmd == 8'h57 || cmd == 8'h52)
            for (int i = 0; i < 4; i++) frame_bytes.push_back(a[8*i +: 8]);
        if (cmd == 8'h57)
            for (int i = 0; i < 4; i++) frame_bytes.push_back(d[8*i +: 8]);
        case (cmd)
            8'h57: begin
                if (halted) begin
                    e.is_wr = 1'b1; e.adr = a; e.dat = d;
                    bus_q.push_back(e);
                    ref_mem[a] = d;
                    exp_tx.push_back(8'h06);
                end else exp_tx.push_back(8'h15);
            end
            8'h52: begin
                if (halted) begin
                    e.is_wr = 1'b0; e.adr = a; e.dat = 32'h0;
                    bus_q.push_back(e);
                    v = ref_read(a);
                    for (int i = 0; i < 4; i++) exp_tx.push_back(v[8*i +: 8]);
                end else exp_tx.push_back(8'h15);
            end
            8'h48: begin halted = 1'b1; exp_tx.push_back(8'h06); end
            8'h47: begin halted = 1'b0; exp_tx.push_back(8'h06); end
            default: exp_tx.push_back(8'h15);
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) @(posedge clk);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((exp_tx.size() != 0 || tx_valid) && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reply_within_bound", 64'(n >= bound), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
        model_frame(cmd, a, d);
        foreach (frame_bytes[i]) send_byte(frame_bytes[i], 3);
        wait_idle(500);
        checkOutput("cpu_n_reset", 64'(cpu_n_reset), 64'(!halted));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0]  cmd;
        logic [31:0] a;
        int          n;
        n_reset  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_dbg_mem_op", 64'(dbg_mem_op), 64'd0);
        checkOutput("rst_dbg_wren", 64'(dbg_wren), 64'd0);
        checkOutput("rst_dbg_adr", 64'(dbg_adr), 64'd0);
        checkOutput("rst_dbg_do", 64'(dbg_do), 64'd0);
        checkOutput("rst_tx_valid", 64'(tx_valid), 64'd0);
        checkOutput("rst_tx_data", 64'(tx_data), 64'd0);
        checkOutput("rst_cpu_n_reset", 64'(cpu_n_reset), 64'd0);
        @(negedge clk);
        n_reset = 1'b1;

        $display("[TB] directed write / read-back");
        applyStimulus(8'h57, 32'h0002_0000, 32'h0000_0137);
        applyStimulus(8'h57, 32'h0000_000C, 32'h0000_0032);
        applyStimulus(8'h52, 32'h0000_000C, 32'h0);

        $display("[TB] run / halt control");
        applyStimulus(8'h47, 32'h0, 32'h0);
        applyStimulus(8'h57, 32'h0000_0040, 32'hCAFE_F00D);
        applyStimulus(8'h52, 32'h0000_000C, 32'h0);
        applyStimulus(8'h47, 32'h0, 32'h0);
        applyStimulus(8'h48, 32'h0, 32'h0);
        applyStimulus(8'h48, 32'h0, 32'h0);

        $display("[TB] unknown command and frame timeout");
        applyStimulus(8'h58, 32'h0, 32'h0);
        exp_tx.push_back(8'h15);
        send_byte(8'h57, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        wait_idle(TIMEOUT + 100);
        applyStimulus(8'h52, 32'h0000_000C, 32'h0);

        $display("[TB] stalled ACK with bytes during WRITE");
        hold_low = 1'b1;
        model_frame(8'h57, 32'h0000_0080, 32'h1234_5678);
        foreach (frame_bytes[i]) send_byte(frame_bytes[i], 2);
        n = 0;
        while (!dbg_mem_op && n < 50) begin @(negedge clk); n++; end
        checkOutput("write_started", 64'(dbg_mem_op), 64'd1);
        send_byte(8'h47, 0);
        send_byte(8'h47, 0);
        n = 0;
        while (!tx_valid && n < 50) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        checkOutput("stall_tx_valid", 64'(tx_valid), 64'd1);
        checkOutput("stall_tx_data", 64'(tx_data), 64'h06);
        hold_low = 1'b0;
        wait_idle(500);
        checkOutput("cpu_n_reset_after_drop", 64'(cpu_n_reset), 64'(!halted));
        applyStimulus(8'h52, 32'h0000_0080, 32'h0);

        $display("[TB] randomized frames");
        for (int k = 0; k < 40; k++) begin
            int r;
            r = $urandom_range(0, 10);
            a = ($urandom_range(0, 2) != 0) ? (32'h1000_0000 | 32'($urandom_range(0, 7) << 2)) : $urandom();
            if (r <= 3) cmd = 8'h57;
            else if (r <= 6) cmd = 8'h52;
            else if (r <= 8) cmd = 8'h48;
            else if (r == 9) cmd = 8'h47;
            else begin
                cmd = 8'($urandom_range(0, 255));
                while (cmd == 8'h57 || cmd == 8'h52 || cmd == 8'h48 || cmd == 8'h47)
                    cmd = 8'($urandom_range(0, 255));
            end
            applyStimulus(cmd, a, $urandom());
        end

        $display("[TB] reset during WRITE");
        applyStimulus(8'h48, 32'h0, 32'h0);
        mon_en = 1'b0;
        send_byte(8'h57, 0);
        for (int i = 0; i < 4; i++) send_byte(8'(i == 1 ? 8'h01 : 8'h00), 0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 0);
        n = 0;
        while (!dbg_mem_op && n < 50) begin @(negedge clk); n++; end
        checkOutput("abort_write_started", 64'(dbg_mem_op), 64'd1);
        @(posedge clk);
        #1;
        n_reset = 1'b0;
        #1;
        checkOutput("abort_dbg_mem_op", 64'(dbg_mem_op), 64'd0);
        checkOutput("abort_dbg_wren", 64'(dbg_wren), 64'd0);
        checkOutput("abort_dbg_adr", 64'(dbg_adr), 64'd0);
        checkOutput("abort_cpu_n_reset", 64'(cpu_n_reset), 64'd0);
        checkOutput("abort_tx_valid", 64'(tx_valid), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        bus_q.delete();
        exp_tx.delete();
        halted = 1'b1;
        mon_en = 1'b1;
        applyStimulus(8'h58, 32'h0, 32'h0);
        applyStimulus(8'h52, 32'h0000_000C, 32'h0);

        checkOutput("bus_invariant_violations", 64'(inv_viol), 64'd0);
        checkOutput("bus_stability_violations", 64'(bus_stab_viol), 64'd0);
        checkOutput("tx_stability_violations", 64'(tx_stab_viol), 64'd0);
        checkOutput("bus_queue_drained", 64'(bus_q.size()), 64'd0);
        checkOutput("tx_queue_drained", 64'(exp_tx.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
